lfsr_sequence_checker: RTL and testbench

LFSR_SEQUENCE_CHECKER -- requirements
Module: lfsr_sequence_checker

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_next.sv | 17 +
 rtl/lfsr_sequence_checker.sv | 162 ++++++++++++++++
 tb/tb_lfsr_sequence_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 4-bit LFSR sequence checker and any generator
// that produces the same sequence.
//   LFSR_W        : LFSR word width
//   TAP_HI/TAP_LO : bit positions XORed to form the new LSB
//   state_t       : checker FSM states (HUNT / VERIFY / LOCKED)
//   lfsr_step()   : next(q) = {q[2:0], q[3]^q[2]}, period 15 over nonzero states
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 2;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// -----------------------------------------------------------------------------
// lfsr_next
// Purely combinational one-step LFSR advance, shared by checker and generator.
// Ports:
//   cur : current LFSR word
//   nxt : word that follows cur in the sequence
// -----------------------------------------------------------------------------
module lfsr_next
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt
);

    assign nxt = lfsr_step(cur);

endmodule

// File: rtl/lfsr_sequence_checker.sv
// -----------------------------------------------------------------------------
// lfsr_sequence_checker
// Hunts for, verifies and then tracks a 4-bit LFSR sequence, counting words
// that break the sequence once locked.
// Parameters:
//   LOCK_MATCHES : consecutive correct predictions in VERIFY to lock (1..15)
//   LOSS_ERRS    : consecutive mismatches in LOCKED that drop lock (1..15)
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (overrides everything)
//   w_in       : received LFSR word
//   valid      : qualifies w_in for one cycle
//   clear_cnt  : synchronous clear of err_count (wins over an increment)
//   locked     : high while in LOCKED (registered)
//   err_pulse  : one-cycle pulse per mismatching word while LOCKED
//   zero_seen  : one-cycle pulse per valid all-zero word
//   err_count  : saturating count of LOCKED mismatches
//   expected   : predicted next word
//   fsm_state  : current FSM state, for observation
//
// Handshake: valid-only stream, no backpressure. A word is consumed on every
// rising edge where valid=1; with valid=0 nothing but the pulses changes.
// All outputs reflect a consumed word one edge after it is sampled.
// -----------------------------------------------------------------------------
module lfsr_sequence_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 3,
    parameter int unsigned LOSS_ERRS    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] w_in,
    input  logic              valid,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic              zero_seen,
    output logic [7:0]        err_count,
    output logic [LFSR_W-1:0] expected,
    output logic [1:0]        fsm_state
);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] exp_q, exp_d;
    logic [3:0]        match_q, match_d;
    logic [3:0]        miss_q, miss_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              locked_q;
    logic              ep_q, ep_d;
    logic              zs_q, zs_d;
    logic              cnt_inc;

    logic [LFSR_W-1:0] nxt_w;
    logic [LFSR_W-1:0] nxt_exp;
    logic              is_zero;
    logic              is_match;

    // Seed path (from the received word) and flywheel path (from prediction).
    lfsr_next u_next_w   (.cur(w_in),  .nxt(nxt_w));
    lfsr_next u_next_exp (.cur(exp_q), .nxt(nxt_exp));

    assign is_zero  = (w_in == '0);
    assign is_match = (w_in == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        miss_d  = miss_q;
        ep_d    = 1'b0;
        zs_d    = 1'b0;
        cnt_inc = 1'b0;

        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (is_zero) begin
                        zs_d = 1'b1;
                    end else begin
                        exp_d   = nxt_w;
                        match_d = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        zs_d    = 1'b1;
                        state_d = HUNT;
                    end else if (is_match) begin
                        exp_d   = nxt_w;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == 4'(LOCK_MATCHES)) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        // Re-seed from the new word; not counted as an error.
                        exp_d   = nxt_w;
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances regardless of the word.
                    exp_d = nxt_exp;
                    if (is_match) begin
                        miss_d = 4'd0;
                    end else begin
                        ep_d    = 1'b1;
                        zs_d    = is_zero;
                        cnt_inc = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q + 4'd1 == 4'(LOSS_ERRS)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (clear_cnt) begin
            cnt_d = 8'd0;
        end else if (cnt_inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            match_q  <= 4'd0;
            miss_q   <= 4'd0;
            cnt_q    <= 8'd0;
            locked_q <= 1'b0;
            ep_q     <= 1'b0;
            zs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            locked_q <= (state_d == LOCKED);
            ep_q     <= ep_d;
            zs_q     <= zs_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = ep_q;
    assign zero_seen = zs_q;
    assign err_count = cnt_q;
    assign expected  = exp_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_sequence_checker
// Directed table of {inputs, expected outputs} records applied one clock each,
// followed by a hand-written saturation/clear sequence driven from the
// documented 15-state sequence.
// -----------------------------------------------------------------------------
module tb_lfsr_sequence_checker;

    localparam logic [1:0] ST_H = 2'd0;
    localparam logic [1:0] ST_V = 2'd1;
    localparam logic [1:0] ST_L = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] w_in = 4'd0;
    logic       valid = 1'b0;
    logic       clear_cnt = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic       zero_seen;
    logic [7:0] err_count;
    logic [3:0] expected;
    logic [1:0] fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    lfsr_sequence_checker dut (
        .clk       (clk),
        .reset     (reset),
        .w_in      (w_in),
        .valid     (valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .zero_seen (zero_seen),
        .err_count (err_count),
        .expected  (expected),
        .fsm_state (fsm_state)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] w;
        logic       clr;
        logic       e_lock;
        logic       e_ep;
        logic       e_zs;
        logic [7:0] e_cnt;
        logic [3:0] e_exp;
        logic [1:0] e_st;
    } vec_t;

    vec_t vq[$];

    // Documented sequence, used as an independent reference for prediction.
    logic [3:0] seq [15];

    task automatic add(input logic rst, input logic v, input logic [3:0] w,
                       input logic clr, input logic e_lock, input logic e_ep,
                       input logic e_zs, input logic [7:0] e_cnt,
                       input logic [3:0] e_exp, input logic [1:0] e_st);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.clr = clr;
        t.e_lock = e_lock; t.e_ep = e_ep; t.e_zs = e_zs;
        t.e_cnt = e_cnt; t.e_exp = e_exp; t.e_st = e_st;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, req);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic v, input logic [3:0] w,
                         input logic clr);
        @(negedge clk);
        reset = rst; valid = v; w_in = w; clear_cnt = clr;
        @(posedge clk);
        #1;
        reset = 1'b0; valid = 1'b0; clear_cnt = 1'b0;
    endtask

    int         idx;
    int         model_cnt;
    logic [3:0] bad_w;

    initial begin
        seq[0]  = 4'b1111; seq[1]  = 4'b1110; seq[2]  = 4'b1100;
        seq[3]  = 4'b1000; seq[4]  = 4'b0001; seq[5]  = 4'b0010;
        seq[6]  = 4'b0100; seq[7]  = 4'b1001; seq[8]  = 4'b0011;
        seq[9]  = 4'b0110; seq[10] = 4'b1101; seq[11] = 4'b1010;
        seq[12] = 4'b0101; seq[13] = 4'b1011; seq[14] = 4'b0111;

        //  rst v  w     clr  lock ep zs cnt    exp    state
        add(1, 0, 4'h0, 0,   0,   0, 0, 8'd0, 4'h0, ST_H); // reset state
        add(0, 1, 4'hF, 0,   0,   0, 0, 8'd0, 4'hE, ST_V); // seed
        add(0, 1, 4'hE, 0,   0,   0, 0, 8'd0, 4'hC, ST_V);
        add(0, 1, 4'hC, 0,   0,   0, 0, 8'd0, 4'h8, ST_V);
        add(0, 1, 4'h8, 0,   1,   0, 0, 8'd0, 4'h1, ST_L); // 3rd match locks
        add(0, 1, 4'h1, 0,   1,   0, 0, 8'd0, 4'h2, ST_L);
        add(0, 1, 4'h3, 0,   1,   1, 0, 8'd1, 4'h4, ST_L); // bad, flywheel
        add(0, 1, 4'h4, 0,   1,   0, 0, 8'd1, 4'h9, ST_L);
        add(0, 1, 4'h9, 0,   1,   0, 0, 8'd1, 4'h3, ST_L);
        for (int i = 0; i < 5; i++)
            add(0, 0, 4'h0, 0, 1, 0, 0, 8'd1, 4'h3, ST_L);   // valid gap
        add(0, 1, 4'h3, 0,   1,   0, 0, 8'd1, 4'h6, ST_L);
        add(0, 0, 4'h5, 0,   1,   0, 0, 8'd1, 4'h6, ST_L); // ignored word
        add(0, 1, 4'h6, 0,   1,   0, 0, 8'd1, 4'hD, ST_L);
        add(0, 1, 4'h0, 0,   1,   1, 1, 8'd2, 4'hA, ST_L); // zero = miss
        add(0, 1, 4'h0, 0,   1,   1, 1, 8'd3, 4'h5, ST_L);
        add(0, 1, 4'h0, 0,   1,   1, 1, 8'd4, 4'hB, ST_L);
        add(0, 1, 4'h0, 0,   0,   1, 1, 8'd5, 4'h7, ST_H); // 4th miss drops
        add(0, 0, 4'h0, 0,   0,   0, 0, 8'd5, 4'h7, ST_H); // pulses end
        add(0, 1, 4'h5, 0,   0,   0, 0, 8'd5, 4'hB, ST_V);
        add(0, 1, 4'hF, 0,   0,   0, 0, 8'd5, 4'hE, ST_V); // re-seed
        add(0, 1, 4'h0, 0,   0,   0, 1, 8'd5, 4'hE, ST_H); // zero in VERIFY
        add(0, 1, 4'h9, 0,   0,   0, 0, 8'd5, 4'h3, ST_V);
        add(0, 1, 4'h3, 0,   0,   0, 0, 8'd5, 4'h6, ST_V);
        add(0, 1, 4'h6, 0,   0,   0, 0, 8'd5, 4'hD, ST_V);
        add(0, 1, 4'hD, 0,   1,   0, 0, 8'd5, 4'hA, ST_L); // re-lock, cnt kept
        add(0, 0, 4'h0, 1,   1,   0, 0, 8'd0, 4'hA, ST_L); // clear
        add(1, 1, 4'hA, 0,   0,   0, 0, 8'd0, 4'h0, ST_H); // reset wins
        add(0, 1, 4'h0, 0,   0,   0, 1, 8'd0, 4'h0, ST_H);
        add(0, 0, 4'h0, 0,   0,   0, 0, 8'd0, 4'h0, ST_H);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].v, vq[i].w, vq[i].clr);
            chk("locked",    i, {7'd0, locked},    {7'd0, vq[i].e_lock});
            chk("err_pulse", i, {7'd0, err_pulse}, {7'd0, vq[i].e_ep});
            chk("zero_seen", i, {7'd0, zero_seen}, {7'd0, vq[i].e_zs});
            chk("err_count", i, err_count,         vq[i].e_cnt);
            chk("expected",  i, {4'd0, expected},  {4'd0, vq[i].e_exp});
            chk("state",     i, {6'd0, fsm_state}, {6'd0, vq[i].e_st});
        end

        // ---- saturation at 255 and clear-vs-increment ----
        drive(1, 0, 4'h0, 0);
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, seq[idx], 0);
            idx = (idx + 1) % 15;
        end
        chk("sat_lock", 1000, {7'd0, locked}, 8'd1);
        model_cnt = 0;
        while (model_cnt < 255) begin
            for (int k = 0; k < 3; k++) begin
                if (model_cnt < 255) begin
                    bad_w = ~seq[idx];
                    drive(0, 1, bad_w, 0);
                    idx = (idx + 1) % 15;
                    model_cnt++;
                    chk("sat_cnt", 1000 + model_cnt, err_count, 8'(model_cnt));
                end
            end
            drive(0, 1, seq[idx], 0);
            idx = (idx + 1) % 15;
            chk("sat_keep_lock", 1000 + model_cnt, {7'd0, locked}, 8'd1);
        end
        chk("sat_exp", 2000, {4'd0, expected}, {4'd0, seq[idx]});

        bad_w = ~seq[idx];
        drive(0, 1, bad_w, 0);
        idx = (idx + 1) % 15;
        chk("sat_hold",  2001, err_count, 8'd255);
        chk("sat_pulse", 2001, {7'd0, err_pulse}, 8'd1);

        bad_w = ~seq[idx];
        drive(0, 1, bad_w, 1);
        idx = (idx + 1) % 15;
        chk("clr_wins",  2002, err_count, 8'd0);
        chk("clr_pulse", 2002, {7'd0, err_pulse}, 8'd1);
        chk("clr_lock",  2002, {7'd0, locked}, 8'd1);
        chk("clr_exp",   2002, {4'd0, expected}, {4'd0, seq[idx]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
